// File: rtl/vga_frame_monitor.sv
// Passive VGA sink: recovers pixel coordinates from hsync/vsync/colour,
// verifies line and frame timing, and reports per-frame lit-pixel totals.
module vga_frame_monitor #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  color,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_on,
  output logic        frame_done,
  output logic [18:0] frame_lit,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA_LO  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA_HI  = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VA_LO  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    S_SEARCH,
    S_ACQUIRE,
    S_LOCKED
  } state_t;

  // Input capture and edge-detect history
  logic       hs_q, vs_q;
  logic       hs_prev_q, vs_prev_q;
  logic [3:0] col_q;
  logic       lit_dly_q;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  state_t     state_q, state_d;
  logic       bad_q, bad_d;
  logic [7:0] err_q, err_d;

  logic        pv_q, pv_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        pon_q, pon_d;

  logic [18:0] lit_q, lit_d;
  logic [18:0] flit_q, flit_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        done_q, done_d;

  logic h_fall, v_fall;
  logic line_err, frame_err;
  logic in_active;

  assign h_fall = hs_prev_q & ~hs_q;
  assign v_fall = vs_prev_q & ~vs_q;

  assign line_err  = h_fall && (hcnt_q != H_LAST);
  assign frame_err = v_fall && (vcnt_q != V_LAST);

  assign in_active = (hcnt_q >= HA_LO) && (hcnt_q < HA_HI) &&
                     (vcnt_q >= VA_LO) && (vcnt_q < VA_HI);

  always_comb begin
    hcnt_d = hcnt_q;
    if (h_fall) begin
      hcnt_d = '0;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end
  end

  // A vsync fall clears the row counter even if hsync falls with it
  always_comb begin
    vcnt_d = vcnt_q;
    if (v_fall) begin
      vcnt_d = '0;
    end else if (h_fall && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    err_d   = err_q;
    flit_d  = flit_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_SEARCH: begin
        if (v_fall) begin
          state_d = S_ACQUIRE;
          bad_d   = 1'b0;
        end
      end
      S_ACQUIRE: begin
        if (v_fall) begin
          if (!bad_q && !line_err && !frame_err) begin
            state_d = S_LOCKED;
          end
          bad_d = 1'b0;
        end else if (line_err) begin
          bad_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if (line_err || frame_err) begin
          state_d = S_SEARCH;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end else if (v_fall) begin
          flit_d = lit_q;
          fcnt_d = fcnt_q + 16'd1;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_SEARCH;
      end
    endcase
  end

  // Pixels seen on the cycle a timing error is detected are not trusted
  always_comb begin
    pv_d  = (state_q == S_LOCKED) && !line_err &&
            !frame_err && in_active;
    px_d  = '0;
    py_d  = '0;
    pon_d = 1'b0;
    if (pv_d) begin
      px_d  = hcnt_q - HA_LO;
      py_d  = vcnt_q - VA_LO;
      pon_d = lit_dly_q;
    end
  end

  always_comb begin
    lit_d = lit_q;
    if (v_fall) begin
      lit_d = '0;
    end else if (pv_q && pon_q) begin
      lit_d = lit_q + 19'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      col_q     <= '0;
      lit_dly_q <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      col_q     <= color;
      lit_dly_q <= |col_q;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_SEARCH;
      bad_q   <= 1'b0;
      err_q   <= '0;
      pv_q    <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pon_q   <= 1'b0;
      lit_q   <= '0;
      flit_q  <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pon_q   <= pon_d;
      lit_q   <= lit_d;
      flit_q  <= flit_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
    end
  end

  assign locked      = (state_q == S_LOCKED);
  assign pix_valid   = pv_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign pix_on      = pon_q;
  assign frame_done  = done_q;
  assign frame_lit   = flit_q;
  assign frame_count = fcnt_q;
  assign err_count   = err_q;

endmodule

// File: doc/vga_frame_monitor.md
# vga_frame_monitor

Passive sink for the 640x480 VGA stream that the game top level drives to the monitor. Consumes hsync, vsync and the 4-bit colour channel exactly as they leave the pins. Recovers pixel coordinates, checks line and frame timing, and reports per-frame lit-pixel totals. Used on-chip as a self-check and in simulation as the scoreboard front end for the renderer.

## Interface
Parameters:
- H_SYNC, 96: hsync pulse width, clocks
- H_BP, 48: horizontal back porch, clocks
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, clocks
- V_SYNC, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, lines

Ports:
- clk, input, 1: 25 MHz pixel clock, same as the VGA generator
- reset, input, 1: asynchronous, active-high; clears all state
- hsync, input, 1: horizontal sync, active-low
- vsync, input, 1: vertical sync, active-low
- color, input, 4: colour channel; a pixel is lit when any bit is 1
- locked, output, 1: timing verified, coordinate outputs valid
- pix_valid, output, 1: current output pixel lies in the active area (only when locked)
- pix_x, output, 10: recovered column, 0..639
- pix_y, output, 10: recovered row, 0..479
- pix_on, output, 1: recovered pixel lit
- frame_done, output, 1: one-cycle pulse at the end of each locked frame
- frame_lit, output, 19: lit-pixel count of the last completed frame
- frame_count, output, 16: completed locked frames, wraps
- err_count, output, 8: timing errors, saturates at 255

## Operation
- Input stage: hsync, vsync and color are registered once. A second register on each sync feeds edge detection. A fall is previous=1 and current=0.
- hcnt (10b): cleared to 0 on an hsync fall; otherwise increments, saturating at 1023. H_TOTAL = 800.
- vcnt (10b): cleared to 0 on a vsync fall; otherwise increments on each hsync fall, saturating at 1023. If both falls occur in the same cycle, the vsync clear wins. V_TOTAL = 525.
- Line error: an hsync fall with hcnt != H_TOTAL-1, checked only outside SEARCH.
- Frame error: a vsync fall with vcnt != V_TOTAL-1, checked only outside SEARCH.
- State machine:
  - SEARCH: waits for a vsync fall, then moves to ACQUIRE.
  - ACQUIRE: a clean frame (no line error) ending in a vsync fall with no frame error moves to LOCKED. Any error keeps the block in ACQUIRE and restarts the frame check from that vsync fall.
  - LOCKED: any line or frame error moves to SEARCH and increments err_count.
- Active area: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- Coordinate outputs: pix_x = hcnt-144 and pix_y = vcnt-35, registered. pix_x, pix_y and pix_on are forced to 0 when the pixel is outside the active area or the block is not locked.
- lit_count (19b): cleared at every vsync fall. Increments when pix_valid and pix_on are both 1.
- At a vsync fall with the state already LOCKED and no frame error: frame_lit <= lit_count, frame_count += 1, frame_done pulses.

## Timing
- Reset values: locked=0, pix_valid=0, pix_x=0, pix_y=0, pix_on=0, frame_done=0, frame_lit=0, frame_count=0, err_count=0; state=SEARCH.
- Reset asserted mid-frame clears everything immediately. Lock is reacquired from scratch.
- Latency: pix_* outputs appear 2 clocks after the corresponding input sample at the pins.
- locked rises 1 clock after the detected vsync fall that closes the first clean frame. This is the second detected vsync fall after reset.
- locked falls 1 clock after the offending sync fall is detected. pix_valid is 0 from that cycle on.
- The transition into LOCKED does not pulse frame_done. The first pulse comes at the following vsync fall.
- The lit-pixel path has no overflow: the maximum count is 307200 < 2^19.

## Test plan
- Reset, then 4 nominal all-black frames -> locked=1 after the 2nd vsync fall; frame_done pulses at the 3rd and 4th falls; frame_lit=0; frame_count=2.
- Locked, single lit pixel at column 100, row 200 -> exactly one cycle with pix_valid=1, pix_on=1, pix_x=100, pix_y=200; frame_lit=1 at the next frame_done.
- Locked, full-white frame -> frame_lit=307200; pix_x runs 0..639 on each of rows 0..479.
- Locked, one line stretched to 801 clocks -> locked=0 one clock after that hsync fall; err_count=1; locked=1 again after two further vsync falls.
- Reset asserted for 3 clocks mid-frame while locked -> all outputs 0 on the first reset cycle; frame_count=0; relock as in the first test.
- 300 consecutive frames with vsync period 524 lines, starting from locked -> err_count=1 (the first bad frame drops lock to SEARCH, then ACQUIRE retries without counting); locked stays 0.
